// File: rtl/mem_wb_pkg.sv
// ============================================================================
// Module      : mem_wb_pkg
// Description : Shared widths and WB control bit positions for MEM/WB stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_wb_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int CTRL_W_DEF   = 2;
    localparam int REG_W_DEF    = 5;
    localparam int CNT_W_DEF    = 16;
    localparam int REGWRITE_BIT = 0;
    localparam int MEMTOREG_BIT = 1;
endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// Module      : pipe_skid_buf
// Description : Two-entry valid/ready pipe: output register plus skid entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             skid_valid
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;
    logic             out_free;

    assign in_fire  = in_valid & in_ready_q;
    // Output register can take new data if empty or draining this edge.
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign skid_valid = skid_valid_q;

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe.sv
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM/WB pipeline register with skid buffer, forwarding tap
//               and saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_pipe
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_wb_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [REG_W-1:0]  write_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] control_wb_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  write_reg_out,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int             PAY_W   = CTRL_W + REG_W + 2 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAY_W-1:0]  in_payload;
    logic [PAY_W-1:0]  out_payload;
    logic              skid_valid;
    logic [CTRL_W-1:0] ctrl_held;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign in_payload = {control_wb_in, write_reg_in, alu_result_in, read_data_in};

    pipe_skid_buf #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_payload),
        .skid_valid (skid_valid)
    );

    assign {ctrl_held, write_reg_out, alu_result_out, read_data_out} = out_payload;

    // A bubble must never write the register file.
    assign control_wb_out = out_valid ? ctrl_held : '0;

    assign fwd_valid = out_valid & ctrl_held[REGWRITE_BIT] & (write_reg_out != '0);
    assign fwd_reg   = write_reg_out;
    assign fwd_data  = ctrl_held[MEMTOREG_BIT] ? read_data_out : alu_result_out;

    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
